image_stream_threshold: RTL

IMAGE_STREAM_THRESHOLD -- requirements
Module: image_stream_threshold

---
 rtl/img_pkg.sv | 24 ++
 rtl/threshold_lane.sv | 45 ++++
 rtl/image_stream_threshold.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/img_pkg.sv
// Shared encodings for the image threshold stream: output modes, FSM states
// and an elaboration-time clog2 helper.
package img_pkg;

  typedef enum logic [1:0] {
    MODE_PASS       = 2'd0,
    MODE_BINARY     = 2'd1,
    MODE_INV_BINARY = 2'd2,
    MODE_TRUNCATE   = 2'd3
  } mode_e;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_VSYNC  = 2'd1;
  localparam logic [1:0] ST_HBLANK = 2'd2;
  localparam logic [1:0] ST_DATA   = 2'd3;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) result++;
    return result;
  endfunction

endpackage

// File: rtl/threshold_lane.sv
// One pixel lane: applies the selected threshold mode to a {B,G,R} pixel.
module threshold_lane
  import img_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int THRESHOLD  = 90
) (
  input  mode_e                   mode_i,
  input  logic [3*DATA_WIDTH-1:0] pix_i,
  output logic [3*DATA_WIDTH-1:0] pix_o
);

  localparam int SUM_W = DATA_WIDTH + 2;
  localparam logic [SUM_W-1:0]      SUM_LIMIT = SUM_W'(3 * THRESHOLD);
  localparam logic [DATA_WIDTH-1:0] CH_LIMIT  = DATA_WIDTH'(THRESHOLD);

  logic [DATA_WIDTH-1:0] chR, chG, chB;
  logic [DATA_WIDTH-1:0] truncR, truncG, truncB;
  logic [SUM_W-1:0]      sum;
  logic                  bright;

  assign chR = pix_i[DATA_WIDTH-1:0];
  assign chG = pix_i[2*DATA_WIDTH-1:DATA_WIDTH];
  assign chB = pix_i[3*DATA_WIDTH-1:2*DATA_WIDTH];

  // Two guard bits keep the three-channel sum from wrapping.
  assign sum    = SUM_W'(chR) + SUM_W'(chG) + SUM_W'(chB);
  assign bright = sum > SUM_LIMIT;

  assign truncR = (chR > CH_LIMIT) ? chR : '0;
  assign truncG = (chG > CH_LIMIT) ? chG : '0;
  assign truncB = (chB > CH_LIMIT) ? chB : '0;

  always_comb begin
    pix_o = pix_i;
    case (mode_i)
      MODE_PASS:       pix_o = pix_i;
      MODE_BINARY:     pix_o = {(3*DATA_WIDTH){bright}};
      MODE_INV_BINARY: pix_o = {(3*DATA_WIDTH){~bright}};
      MODE_TRUNCATE:   pix_o = {truncB, truncG, truncR};
      default:         pix_o = pix_i;
    endcase
  end

endmodule

// File: rtl/image_stream_threshold.sv
// Streams a frame bottom-up out of memory with VSYNC/HBLANK timing and
// applies a per-lane threshold, with a fixed two-cycle read-to-output latency.
module image_stream_threshold
  import img_pkg::*;
#(
  parameter int IMAGE_WIDTH    = 768,
  parameter int IMAGE_HEIGHT   = 512,
  parameter int PIXELS_PER_CLK = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int START_DELAY    = 100,
  parameter int HSYNC_DELAY    = 160,
  parameter int THRESHOLD      = 90
) (
  input  logic                                                    clk,
  input  logic                                                    reset,
  input  logic                                                    start,
  input  logic [1:0]                                              mode,
  output logic                                                    mem_rd_en,
  output logic [clog2(IMAGE_WIDTH*IMAGE_HEIGHT/PIXELS_PER_CLK)-1:0] mem_addr,
  input  logic [PIXELS_PER_CLK*3*DATA_WIDTH-1:0]                  mem_rdata,
  output logic [PIXELS_PER_CLK*3*DATA_WIDTH-1:0]                  pix_data,
  output logic                                                    pix_valid,
  output logic                                                    vsync,
  output logic                                                    hsync,
  output logic                                                    done
);

  localparam int WORDS_PER_ROW = IMAGE_WIDTH / PIXELS_PER_CLK;
  localparam int ADDR_W   = clog2(IMAGE_WIDTH * IMAGE_HEIGHT / PIXELS_PER_CLK);
  localparam int BUS_W    = PIXELS_PER_CLK * 3 * DATA_WIDTH;
  localparam int LANE_W   = 3 * DATA_WIDTH;
  localparam int CNT_MAX  = (START_DELAY > HSYNC_DELAY)
                            ? ((START_DELAY > WORDS_PER_ROW) ? START_DELAY : WORDS_PER_ROW)
                            : ((HSYNC_DELAY > WORDS_PER_ROW) ? HSYNC_DELAY : WORDS_PER_ROW);
  localparam int CNT_W    = clog2(CNT_MAX + 1);
  localparam int ROW_W    = clog2(IMAGE_HEIGHT + 1);

  if (!(PIXELS_PER_CLK == 1 || PIXELS_PER_CLK == 2 || PIXELS_PER_CLK == 4) ||
      (IMAGE_WIDTH % PIXELS_PER_CLK) != 0) begin : g_bad_config
    $fatal(1, "image_stream_threshold: illegal PIXELS_PER_CLK or IMAGE_WIDTH");
  end

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] rowBase_q, rowBase_d;
  mode_e             mode_q, mode_d;

  logic              rdEn, lastRd;
  logic              rdValid_q, rdLast_q, pixValid_q, pixLast_q, done_q;
  logic [BUS_W-1:0]  pixData_q, pixData_d;

  // One counter is reused for the vsync, blanking and column phases.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    rowBase_d = rowBase_q;
    mode_d    = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_VSYNC;
          cnt_d     = '0;
          row_d     = '0;
          rowBase_d = ADDR_W'((IMAGE_HEIGHT - 1) * WORDS_PER_ROW);
          mode_d    = mode_e'(mode);
        end
      end
      ST_VSYNC: begin
        if (cnt_q == CNT_W'(START_DELAY - 1)) begin
          state_d = ST_HBLANK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HBLANK: begin
        if (cnt_q == CNT_W'(HSYNC_DELAY - 1)) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_W'(WORDS_PER_ROW - 1)) begin
          cnt_d = '0;
          if (row_q == ROW_W'(IMAGE_HEIGHT - 1)) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_HBLANK;
            row_d     = row_q + ROW_W'(1);
            rowBase_d = rowBase_q - ADDR_W'(WORDS_PER_ROW);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rdEn   = (state_q == ST_DATA);
  assign lastRd = rdEn && (cnt_q == CNT_W'(WORDS_PER_ROW - 1)) &&
                  (row_q == ROW_W'(IMAGE_HEIGHT - 1));

  for (genvar lane = 0; lane < PIXELS_PER_CLK; lane++) begin : g_lane
    threshold_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .THRESHOLD (THRESHOLD)
    ) u_lane (
      .mode_i(mode_q),
      .pix_i (mem_rdata[lane*LANE_W +: LANE_W]),
      .pix_o (pixData_d[lane*LANE_W +: LANE_W])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      row_q      <= '0;
      rowBase_q  <= '0;
      mode_q     <= MODE_PASS;
      rdValid_q  <= 1'b0;
      rdLast_q   <= 1'b0;
      pixValid_q <= 1'b0;
      pixLast_q  <= 1'b0;
      done_q     <= 1'b0;
      pixData_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      rowBase_q  <= rowBase_d;
      mode_q     <= mode_d;
      rdValid_q  <= rdEn;
      rdLast_q   <= lastRd;
      pixValid_q <= rdValid_q;
      pixLast_q  <= rdLast_q;
      done_q     <= pixLast_q;
      pixData_q  <= pixData_d;
    end
  end

  // Outputs are forced low for the whole time reset is held, not just after its first edge.
  assign mem_rd_en = rdEn & ~reset;
  assign mem_addr  = (rdEn && !reset) ? (rowBase_q + ADDR_W'(cnt_q)) : '0;
  assign vsync     = (state_q == ST_VSYNC) & ~reset;
  assign pix_valid = pixValid_q & ~reset;
  assign hsync     = pixValid_q & ~reset;
  assign done      = done_q & ~reset;
  assign pix_data  = reset ? '0 : pixData_q;

endmodule
